// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: priority resolution, INT/INTA sequencing, vector bytes, OCW2 EOI decode.
// Optional macro AUTO_EOI_EN adds the auto_eoi input (automatic EOI after the final INTA pulse).
module interrupt_ack_sequencer #(
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inta_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] highest_level_in_service,
    input  logic       mode_8086,
    input  logic [4:0] vector_base,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
`ifdef AUTO_EOI_EN
    input  logic       auto_eoi,
`endif
    output logic       interrupt_to_cpu,
    output logic       latch_in_service,
    output logic [7:0] interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

    localparam logic [2:0] SPURIOUS_LVL = 3'(SPURIOUS_LEVEL);

    state_t     state_q, state_d;
    logic       inta_n_q;
    logic       int_q, int_d;
    logic       latch_q, latch_d;
    logic [7:0] interrupt_q, interrupt_d;
    logic [2:0] level_q, level_d;
    logic [7:0] eoi_q, eoi_d;
    logic [2:0] rotate_q, rotate_d;
    logic [7:0] data_q, data_d;
    logic       oe_q, oe_d;

    logic       inta_fall, inta_rise, final_rise;
    logic       win_found, blocked;
    logic [2:0] win_level, scan_lvl, isr_level;
    logic       unused_ocw2_bits;

    assign inta_fall  = inta_n_q & ~inta_n;
    assign inta_rise  = ~inta_n_q & inta_n;
    assign final_rise = inta_rise & (((state_q == ACK2) & mode_8086) | (state_q == ACK3));
    assign unused_ocw2_bits = ^ocw2_data[4:3];

    // Scan from IR(rotate+1) downwards; an in-service level blocks itself and everything below it.
    always_comb begin : resolve
        win_found = 1'b0;
        win_level = '0;
        blocked   = 1'b0;
        scan_lvl  = '0;
        for (int i = 0; i < 8; i++) begin
            scan_lvl = rotate_q + 3'd1 + 3'(i);
            if (highest_level_in_service[scan_lvl])
                blocked = 1'b1;
            if (!blocked && !win_found && interrupt_request[scan_lvl]) begin
                win_found = 1'b1;
                win_level = scan_lvl;
            end
        end
    end

    always_comb begin : isr_encode
        isr_level = '0;
        for (int i = 0; i < 8; i++)
            if (highest_level_in_service[i])
                isr_level = 3'(i);
    end

`ifdef AUTO_EOI_EN
    logic spurious_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            spurious_q <= 1'b0;
        else if ((state_q == IDLE) && inta_fall)
            spurious_q <= ~win_found;
    end
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin : next_state
        state_d     = state_q;
        int_d       = 1'b0;
        latch_d     = 1'b0;
        interrupt_d = interrupt_q;
        level_d     = level_q;
        eoi_d       = '0;
        rotate_d    = rotate_q;
        data_d      = data_q;
        oe_d        = inta_rise ? 1'b0 : oe_q;

        case (state_q)
            IDLE: begin
                int_d = win_found;
                if (inta_fall) begin
                    int_d   = 1'b0;
                    state_d = ACK1;
                    latch_d = win_found;
                    level_d = win_found ? win_level : SPURIOUS_LVL;
                    interrupt_d = 8'b1 << (win_found ? win_level : SPURIOUS_LVL);
                    data_d  = 8'hCD;
                    oe_d    = ~mode_8086;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_d = ACK2;
                    data_d  = mode_8086 ? {vector_base, level_q} : {level_q, 5'b0};
                    oe_d    = 1'b1;
                end
            end
            ACK2: begin
                if (final_rise) begin
                    state_d = IDLE;
                end else if (!mode_8086 && inta_fall) begin
                    state_d = ACK3;
                    data_d  = {3'b0, vector_base};
                    oe_d    = 1'b1;
                end
            end
            ACK3: begin
                if (final_rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ocw2_write) begin
            case (ocw2_data[7:5])
                3'b001: eoi_d = highest_level_in_service;
                3'b011: eoi_d = 8'b1 << ocw2_data[2:0];
                3'b101: begin
                    eoi_d = highest_level_in_service;
                    if (|highest_level_in_service)
                        rotate_d = isr_level;
                end
                3'b111: begin
                    eoi_d    = 8'b1 << ocw2_data[2:0];
                    rotate_d = ocw2_data[2:0];
                end
                3'b110:  rotate_d = ocw2_data[2:0];
                default: ;
            endcase
        end

`ifdef AUTO_EOI_EN
        if (auto_eoi && final_rise && !spurious_q)
            eoi_d = eoi_d | interrupt_q;
`endif
    end

    // NOTE: inta_n_q resets low so an INTA already held low at reset release is not seen as a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            inta_n_q    <= 1'b0;
            int_q       <= 1'b0;
            latch_q     <= 1'b0;
            interrupt_q <= '0;
            level_q     <= '0;
            eoi_q       <= '0;
            rotate_q    <= 3'd7;
            data_q      <= '0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_n_q    <= inta_n;
            int_q       <= int_d;
            latch_q     <= latch_d;
            interrupt_q <= interrupt_d;
            level_q     <= level_d;
            eoi_q       <= eoi_d;
            rotate_q    <= rotate_d;
            data_q      <= data_d;
            oe_q        <= oe_d;
        end
    end

    assign interrupt_to_cpu = int_q;
    assign latch_in_service = latch_q;
    assign interrupt        = interrupt_q;
    assign end_of_interrupt = eoi_q;
    assign priority_rotate  = rotate_q;
    assign data_out         = oe_q ? data_q : 8'h00;
    assign data_out_enable  = oe_q;

endmodule
